fpga_rst_supervisor: RTL and testbench

FPGA_RST_SUPERVISOR -- requirements
Module: fpga_rst_supervisor

---
 rtl/fpga_rst_supervisor.sv | 184 ++++++++++++++++++
 tb/tb_fpga_rst_supervisor.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_rst_supervisor.sv
// Reset supervisor: pulses the MMCM reset, qualifies LOCKED, then releases
// the per-domain resets in order with retry and a sticky failure state.
`timescale 1ns/1ps

module fpga_rst_supervisor #(
    parameter int NUM_RST      = 3,
    parameter int PLL_RST_CYC  = 16,
    parameter int LOCK_FILT    = 64,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int SEQ_GAP      = 8,
    parameter int MAX_RETRY    = 3
) (
    input  logic               clk_ext,
    input  logic               srst_n,
    input  logic               pll_lock,
    input  logic               force_rst,
    output logic               pll_rst,
    output logic [NUM_RST-1:0] rst_n_o,
    output logic               ready,
    output logic               fail,
    output logic [3:0]         retry_cnt
);

    localparam int PW = (PLL_RST_CYC > 1) ? $clog2(PLL_RST_CYC) : 1;
    localparam int FW = (LOCK_FILT > 1) ? $clog2(LOCK_FILT) : 1;
    localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int RW = $clog2(NUM_RST * SEQ_GAP + 1);

    localparam logic [PW-1:0] PLL_LAST  = PW'(PLL_RST_CYC - 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILT - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT - 1);
    localparam logic [RW-1:0] REL_SAT   = RW'(NUM_RST * SEQ_GAP);
    localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_PLLRST,
        S_WAITLOCK,
        S_FILTER,
        S_RELEASE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t              r_state;
    logic [1:0]          r_sync;
    logic [PW-1:0]       r_pcnt;
    logic [FW-1:0]       r_filt;
    logic [TW-1:0]       r_tmo;
    logic [RW-1:0]       r_rel;
    logic [3:0]          r_retry;
    logic                r_pll_rst;
    logic [NUM_RST-1:0]  r_rst_n;
    logic                r_ready;
    logic                r_fail;

    logic                w_lock_s;
    logic                w_tmo_hit;
    logic                w_timeout;
    logic                w_lock_loss;
    logic                w_retry_ok;
    logic                w_restart;
    logic [RW-1:0]       w_rel_nxt;
    logic [NUM_RST-1:0]  w_rel_mask;

    assign w_lock_s    = r_sync[1];
    assign w_tmo_hit   = (r_tmo == TMO_LAST);
    assign w_timeout   = ((r_state == S_WAITLOCK) || (r_state == S_FILTER))
                         && w_tmo_hit;
    assign w_lock_loss = ((r_state == S_RELEASE) || (r_state == S_RUN))
                         && !w_lock_s;
    assign w_retry_ok  = (r_retry < RETRY_MAX);
    assign w_restart   = force_rst || w_lock_loss || (w_timeout && w_retry_ok);

    // Release timeline: saturating cycle count and which outputs it has passed
    always_comb begin
        w_rel_mask = '0;
        w_rel_nxt  = (r_rel == REL_SAT) ? r_rel : r_rel + RW'(1);
        for (int k = 0; k < NUM_RST; k++) begin
            w_rel_mask[k] = (w_rel_nxt >= RW'((k + 1) * SEQ_GAP));
        end
    end

    // Sequencer FSM with lock synchronizer and registered outputs
    always_ff @(posedge clk_ext) begin
        if (!srst_n) begin
            r_state   <= S_PLLRST;
            r_sync    <= '0;
            r_pcnt    <= '0;
            r_filt    <= '0;
            r_tmo     <= '0;
            r_rel     <= '0;
            r_retry   <= '0;
            r_pll_rst <= 1'b1;
            r_rst_n   <= '0;
            r_ready   <= 1'b0;
            r_fail    <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], pll_lock};
            if (w_restart) begin
                r_state   <= S_PLLRST;
                r_pcnt    <= '0;
                r_filt    <= '0;
                r_tmo     <= '0;
                r_rel     <= '0;
                r_pll_rst <= 1'b1;
                r_rst_n   <= '0;
                r_ready   <= 1'b0;
                r_fail    <= 1'b0;
                if (force_rst) begin
                    r_retry <= '0;
                end else if (w_timeout) begin
                    r_retry <= r_retry + 4'd1;
                end
            end else if (w_timeout) begin
                r_state   <= S_FAIL;
                r_pll_rst <= 1'b0;
                r_rst_n   <= '0;
                r_ready   <= 1'b0;
                r_fail    <= 1'b1;
            end else begin
                unique case (r_state)
                    S_PLLRST: begin
                        if (r_pcnt == PLL_LAST) begin
                            r_state   <= S_WAITLOCK;
                            r_pll_rst <= 1'b0;
                            r_tmo     <= '0;
                            r_filt    <= '0;
                        end else begin
                            r_pcnt <= r_pcnt + PW'(1);
                        end
                    end
                    S_WAITLOCK: begin
                        r_tmo <= r_tmo + TW'(1);
                        if (w_lock_s) begin
                            r_state <= S_FILTER;
                            r_filt  <= '0;
                        end
                    end
                    S_FILTER: begin
                        r_tmo <= r_tmo + TW'(1);
                        if (!w_lock_s) begin
                            r_state <= S_WAITLOCK;
                            r_filt  <= '0;
                        end else if (r_filt == FILT_LAST) begin
                            r_state <= S_RELEASE;
                            r_rel   <= '0;
                        end else begin
                            r_filt <= r_filt + FW'(1);
                        end
                    end
                    S_RELEASE: begin
                        if (r_rst_n[NUM_RST-1]) begin
                            r_state <= S_RUN;
                            r_ready <= 1'b1;
                            r_retry <= '0;
                        end else begin
                            r_rel   <= w_rel_nxt;
                            r_rst_n <= w_rel_mask;
                        end
                    end
                    S_RUN: begin
                        r_rst_n <= '1;
                        r_ready <= 1'b1;
                    end
                    S_FAIL: begin
                        r_fail <= 1'b1;
                    end
                    default: begin
                        r_state   <= S_PLLRST;
                        r_pll_rst <= 1'b1;
                        r_pcnt    <= '0;
                    end
                endcase
            end
        end
    end

    assign pll_rst   = r_pll_rst;
    assign rst_n_o   = r_rst_n;
    assign ready     = r_ready;
    assign fail      = r_fail;
    assign retry_cnt = r_retry;

endmodule

// File: tb/tb_fpga_rst_supervisor.sv
// Bench for fpga_rst_supervisor: four parameter sets driven in parallel,
// each checked every cycle against a timeline model, plus literal checks.
`timescale 1ns/1ps

module tb_fpga_rst_supervisor;

    localparam int PH_PR = 0;
    localparam int PH_WL = 1;
    localparam int PH_FI = 2;
    localparam int PH_RE = 3;
    localparam int PH_RU = 4;
    localparam int PH_FA = 5;

    localparam int P_N   [4] = '{3, 8, 1, 1};
    localparam int P_PRC [4] = '{16, 2, 2, 1};
    localparam int P_LF  [4] = '{64, 4, 40, 4};
    localparam int P_LT  [4] = '{4096, 32, 32, 64};
    localparam int P_G   [4] = '{8, 1, 1, 1};
    localparam int P_MR  [4] = '{3, 2, 1, 0};

    typedef struct packed {
        int   ph;
        int   t;
        int   tmo;
        int   filt;
        int   retry;
        logic s1;
        logic s2;
    } mdl_t;

    logic clk = 1'b0;
    logic srst_n, pll_lock, force_rst;

    logic       pr0, rd0, fl0;
    logic [2:0] rs0;
    logic [3:0] rc0;
    logic       pr1, rd1, fl1;
    logic [7:0] rs1;
    logic [3:0] rc1;
    logic       pr2, rd2, fl2;
    logic [0:0] rs2;
    logic [3:0] rc2;
    logic       pr3, rd3, fl3;
    logic [0:0] rs3;
    logic [3:0] rc3;

    logic [14:0] obs [4];
    mdl_t        m   [4];

    int  n_checks = 0;
    int  n_pass   = 0;
    bit  cmp_en   = 0;

    always #5 clk = ~clk;

    fpga_rst_supervisor dut0 (
        .clk_ext(clk), .srst_n(srst_n), .pll_lock(pll_lock),
        .force_rst(force_rst), .pll_rst(pr0), .rst_n_o(rs0),
        .ready(rd0), .fail(fl0), .retry_cnt(rc0)
    );

    fpga_rst_supervisor #(
        .NUM_RST(8), .PLL_RST_CYC(2), .LOCK_FILT(4),
        .LOCK_TIMEOUT(32), .SEQ_GAP(1), .MAX_RETRY(2)
    ) dut1 (
        .clk_ext(clk), .srst_n(srst_n), .pll_lock(pll_lock),
        .force_rst(force_rst), .pll_rst(pr1), .rst_n_o(rs1),
        .ready(rd1), .fail(fl1), .retry_cnt(rc1)
    );

    fpga_rst_supervisor #(
        .NUM_RST(1), .PLL_RST_CYC(2), .LOCK_FILT(40),
        .LOCK_TIMEOUT(32), .SEQ_GAP(1), .MAX_RETRY(1)
    ) dut2 (
        .clk_ext(clk), .srst_n(srst_n), .pll_lock(pll_lock),
        .force_rst(force_rst), .pll_rst(pr2), .rst_n_o(rs2),
        .ready(rd2), .fail(fl2), .retry_cnt(rc2)
    );

    fpga_rst_supervisor #(
        .NUM_RST(1), .PLL_RST_CYC(1), .LOCK_FILT(4),
        .LOCK_TIMEOUT(64), .SEQ_GAP(1), .MAX_RETRY(0)
    ) dut3 (
        .clk_ext(clk), .srst_n(srst_n), .pll_lock(pll_lock),
        .force_rst(force_rst), .pll_rst(pr3), .rst_n_o(rs3),
        .ready(rd3), .fail(fl3), .retry_cnt(rc3)
    );

    assign obs[0] = {pr0, rd0, fl0, rc0, 5'b0, rs0};
    assign obs[1] = {pr1, rd1, fl1, rc1, rs1};
    assign obs[2] = {pr2, rd2, fl2, rc2, 7'b0, rs2};
    assign obs[3] = {pr3, rd3, fl3, rc3, 7'b0, rs3};

    // One clock of the supervisor's rules, expressed as phase timelines
    function automatic mdl_t mstep(mdl_t c, logic rs_n, logic frc,
                                   logic lk, int i);
        mdl_t n;
        logic ls;
        n = c;
        if (!rs_n) begin
            n.ph = PH_PR; n.t = 0; n.tmo = 0; n.filt = 0;
            n.retry = 0; n.s1 = 1'b0; n.s2 = 1'b0;
            return n;
        end
        ls   = c.s2;
        n.s2 = c.s1;
        n.s1 = lk;
        if (frc) begin
            n.ph = PH_PR; n.t = 0; n.tmo = 0; n.filt = 0; n.retry = 0;
            return n;
        end
        case (c.ph)
            PH_PR: begin
                n.t = c.t + 1;
                if (n.t == P_PRC[i]) begin
                    n.ph = PH_WL; n.tmo = 0;
                end
            end
            PH_WL, PH_FI: begin
                n.tmo = c.tmo + 1;
                if (n.tmo >= P_LT[i]) begin
                    if (c.retry < P_MR[i]) begin
                        n.retry = c.retry + 1; n.ph = PH_PR; n.t = 0;
                    end else begin
                        n.ph = PH_FA;
                    end
                end else if (c.ph == PH_WL) begin
                    if (ls) begin
                        n.ph = PH_FI; n.filt = 0;
                    end
                end else if (!ls) begin
                    n.ph = PH_WL;
                end else begin
                    n.filt = c.filt + 1;
                    if (n.filt >= P_LF[i]) begin
                        n.ph = PH_RE; n.t = 0;
                    end
                end
            end
            PH_RE: begin
                if (!ls) begin
                    n.ph = PH_PR; n.t = 0;
                end else begin
                    n.t = c.t + 1;
                    if (n.t > P_N[i] * P_G[i]) begin
                        n.ph = PH_RU; n.retry = 0;
                    end
                end
            end
            PH_RU: begin
                if (!ls) begin
                    n.ph = PH_PR; n.t = 0;
                end
            end
            default: ;
        endcase
        return n;
    endfunction

    function automatic logic [14:0] mexp(mdl_t c, int i);
        logic [7:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            if (k < P_N[i]) begin
                if (c.ph == PH_RU) r[k] = 1'b1;
                else if (c.ph == PH_RE && c.t >= (k + 1) * P_G[i]) r[k] = 1'b1;
            end
        end
        return {c.ph == PH_PR, c.ph == PH_RU, c.ph == PH_FA, 4'(c.retry), r};
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            m[i] = mstep(m[i], srst_n, force_rst, pll_lock, i);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (obs[i] === mexp(m[i], i)) n_pass++;
                else $display("FAIL model dut%0d t=%0t got=%h exp=%h",
                              i, $time, obs[i], mexp(m[i], i));
            end
        end
    end

    task automatic check(input string nm, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    endtask

    task automatic pulse_force();
        force_rst = 1'b1;
        @(negedge clk);
        force_rst = 1'b0;
    endtask

    task automatic wait_pll_fall();
        int k;
        k = 0;
        while (pr0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("pll_rst_fall", int'(pr0), 0);
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!rd0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("ready_reached", int'(rd0), 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int fall0, r0, r1, r2, rdy, r3, rdy3, n, pulses, seen, seg;
        logic prev;
        srst_n = 1'b0; force_rst = 1'b0; pll_lock = 1'b1;
        repeat (3) @(negedge clk);
        cmp_en = 1;
        check("reset_pll_rst", int'(pr0), 1);
        check("reset_rst_n", int'(rs0), 0);
        check("reset_ready", int'(rd0), 0);
        check("reset_fail", int'(fl0), 0);
        check("reset_retry", int'(rc0), 0);

        // steady lock from reset release
        srst_n = 1'b1;
        fall0 = -1; r0 = -1; r1 = -1; r2 = -1; rdy = -1; r3 = -1; rdy3 = -1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (fall0 < 0 && !pr0) fall0 = c;
            if (r0 < 0 && rs0[0]) r0 = c;
            if (r1 < 0 && rs0[1]) r1 = c;
            if (r2 < 0 && rs0[2]) r2 = c;
            if (rdy < 0 && rd0) rdy = c;
            if (r3 < 0 && rs3[0]) r3 = c;
            if (rdy3 < 0 && rd3) rdy3 = c;
            if (c == 11) check("n8_order_at11", int'(rs1), 8'h0F);
        end
        check("pll_rst_width", fall0, 16);
        check("rst0_rise", r0, 89);
        check("rst1_rise", r1, 97);
        check("rst2_rise", r2, 105);
        check("ready_rise", rdy, 106);
        check("n1_rst_rise", r3, 8);
        check("n1_ready_rise", rdy3, 9);
        check("filter_tmo_fail", int'(fl2), 1);
        check("filter_tmo_retry", int'(rc2), 1);
        check("run_retry", int'(rc0), 0);

        // one-cycle lock glitch in the middle of filtering
        pulse_force();
        wait_pll_fall();
        repeat (41) @(negedge clk);
        pll_lock = 1'b0;
        @(negedge clk);
        pll_lock = 1'b1;
        n = 0;
        while (!rs0[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("glitch_release", n, 75);
        wait_ready();

        // lock loss while running
        pll_lock = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(rs0 == 3'b000 && !rd0) && n < 10);
        check("lockloss_latency", n, 3);
        pll_lock = 1'b1;
        wait_ready();
        check("relock_retry", int'(rc0), 0);
        check("relock_rst", int'(rs0), 7);

        // permanent lock loss until failure
        pll_lock = 1'b0;
        pulses = 0; seen = 0; prev = pr0; n = 0;
        while (!fl0 && n < 20000) begin
            @(negedge clk);
            n++;
            if (pr0 && !prev) begin
                pulses++;
                seen = seen * 16 + int'(rc0);
            end
            prev = pr0;
        end
        check("fail_pulses", pulses, 4);
        check("fail_retry_seq", seen, 16'h0123);
        check("fail_flag", int'(fl0), 1);
        check("fail_rst", int'(rs0), 0);
        check("fail_pll_rst", int'(pr0), 0);
        check("fail_retry", int'(rc0), 3);
        force_rst = 1'b1;
        @(negedge clk);
        check("force_pll_rst", int'(pr0), 1);
        check("force_retry", int'(rc0), 0);
        check("force_fail", int'(fl0), 0);
        force_rst = 1'b0;

        // force in the very cycle the timeout would fire
        wait_pll_fall();
        repeat (4095) @(negedge clk);
        force_rst = 1'b1;
        @(negedge clk);
        check("force_vs_tmo_pll", int'(pr0), 1);
        check("force_vs_tmo_retry", int'(rc0), 0);
        force_rst = 1'b0;

        // synchronous reset partway through the release sequence
        pll_lock = 1'b1;
        pulse_force();
        n = 0;
        while (rs0 != 3'b001 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("partial_release", int'(rs0), 1);
        srst_n = 1'b0;
        @(negedge clk);
        check("abort_pll_rst", int'(pr0), 1);
        check("abort_rst", int'(rs0), 0);
        check("abort_ready", int'(rd0), 0);
        check("abort_fail", int'(fl0), 0);
        check("abort_retry", int'(rc0), 0);
        srst_n = 1'b1;

        // randomized lock behaviour with occasional force and reset
        seg = 0;
        for (int c = 0; c < 5000; c++) begin
            if (seg == 0) begin
                pll_lock = ~pll_lock;
                if (pll_lock) seg = $urandom_range(20, 400);
                else if ($urandom_range(0, 7) == 0) seg = $urandom_range(30, 100);
                else seg = $urandom_range(1, 8);
            end
            seg--;
            force_rst = ($urandom_range(0, 399) == 0);
            srst_n = ($urandom_range(0, 799) != 0);
            @(negedge clk);
        end
        force_rst = 1'b0;
        srst_n = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
